// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM states and decode helpers
// for the ALU instruction sequencer.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_NAND = 3'b001;
  localparam logic [2:0] OP_CMP  = 3'b010;
  localparam logic [2:0] OP_SHL  = 3'b011;
  localparam logic [2:0] OP_SHR  = 3'b100;
  localparam logic [2:0] OP_BEQ  = 3'b101;
  localparam logic [2:0] OP_IDLE = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WB
  } state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [1:0] rd;
  } ctl_t;

  function automatic logic op_legal(
    input logic [2:0] op
  );
    return op <= OP_BEQ;
  endfunction

  function automatic logic op_writes(
    input logic [2:0] op
  );
    return op <= OP_SHR;
  endfunction

endpackage

// File: rtl/seq_regfile.sv
// 4-entry register file: two operand reads,
// one debug read, one write port.
module seq_regfile #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [1:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [1:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] rf [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else if (we) begin
      rf[waddr] <= wdata;
    end
  end

  assign rdata_a  = rf[raddr_a];
  assign rdata_b  = rf[raddr_b];
  assign dbg_data = rf[dbg_sel];

endmodule

// File: rtl/alu_sequencer.sv
// Three-state sequencer feeding an external ALU
// from a local register file.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [7:0]        instr,
  output logic              instr_ready,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              pre_we,
  input  logic [1:0]        pre_sel,
  input  logic [DATA_W-1:0] pre_data,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic              done,
  output logic              branch_taken,
  output logic              illegal
);

  state_t            state;
  state_t            state_nxt;
  ctl_t              ctl;
  logic              zero_q;
  logic              hs;
  logic              we;
  logic [1:0]        waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;
  logic              unused_bit;

  assign unused_bit  = instr[4];
  assign instr_ready = (state == S_IDLE);
  assign hs          = instr_valid && instr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:
        if (hs)
          state_nxt = op_legal(instr[7:5]) ? S_EXEC : S_WB;
      S_EXEC:  state_nxt = S_WB;
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    alu_op       = OP_IDLE;
    done         = 1'b0;
    branch_taken = 1'b0;
    illegal      = 1'b0;
    unique case (state)
      S_EXEC: alu_op = ctl.op;
      S_WB: begin
        done         = 1'b1;
        branch_taken = (ctl.op == OP_BEQ) && zero_q;
        illegal      = !op_legal(ctl.op);
      end
      default: ;
    endcase
  end

  // Operands are captured at handshake so rd may alias rs1/rs2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl    <= '{op: OP_IDLE, rd: 2'd0};
      alu_a  <= '0;
      alu_b  <= '0;
      zero_q <= 1'b0;
    end else begin
      if (hs) begin
        ctl   <= '{op: instr[7:5], rd: instr[3:2]};
        alu_a <= rdata_a;
        alu_b <= rdata_b;
      end
      if (state == S_EXEC && ctl.op == OP_BEQ)
        zero_q <= alu_zero;
    end
  end

  // Preload only in IDLE, writeback only in EXEC: never both.
  always_comb begin
    we    = 1'b0;
    waddr = pre_sel;
    wdata = pre_data;
    if (state == S_EXEC) begin
      we    = op_writes(ctl.op);
      waddr = ctl.rd;
      wdata = alu_result;
    end else if (state == S_IDLE) begin
      we    = pre_we;
    end
  end

  seq_regfile #(
    .DATA_W(DATA_W)
  ) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (instr[3:2]),
    .rdata_a (rdata_a),
    .raddr_b (instr[1:0]),
    .rdata_b (rdata_b),
    .dbg_sel (dbg_sel),
    .dbg_data(dbg_data)
  );

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed-vector bench for alu_sequencer with
// a behavioural ALU model on its ALU port.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic [7:0] instr;
  logic       instr_ready;
  logic [2:0] alu_op;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       pre_we;
  logic [1:0] pre_sel;
  logic [7:0] pre_data;
  logic [1:0] dbg_sel;
  logic [7:0] dbg_data;
  logic       done;
  logic       branch_taken;
  logic       illegal;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.DATA_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .pre_we      (pre_we),
    .pre_sel     (pre_sel),
    .pre_data    (pre_data),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data),
    .done        (done),
    .branch_taken(branch_taken),
    .illegal     (illegal)
  );

  always_comb begin
    alu_result = 8'h00;
    case (alu_op)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = ~(alu_a & alu_b);
      3'b010:  alu_result = {7'd0, alu_a == alu_b};
      3'b011:  alu_result = alu_a << 1;
      3'b100:  alu_result = {alu_a[7], alu_a[7:1]};
      default: alu_result = 8'h00;
    endcase
    alu_zero = (alu_a == alu_b);
  end

  task automatic chk(
    input string      tag,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h want %02h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rf(
    input logic [1:0] idx,
    input logic [7:0] exp
  );
    dbg_sel = idx;
    #0.1;
    chk($sformatf("rf%0d", idx), dbg_data, exp);
  endtask

  task automatic preload(
    input logic [1:0] sel,
    input logic [7:0] data
  );
    pre_we   = 1'b1;
    pre_sel  = sel;
    pre_data = data;
    tick();
    pre_we   = 1'b0;
  endtask

  task automatic do_instr(
    input logic [7:0] ins,
    input logic [7:0] ea,
    input logic [7:0] eb,
    input logic       ebr,
    input logic       eill
  );
    instr_valid = 1'b1;
    instr       = ins;
    tick();
    instr_valid = 1'b0;
    pre_we      = 1'b0;
    if (!eill) begin
      chk("exec_op", {5'd0, alu_op}, {5'd0, ins[7:5]});
      chk("exec_a", alu_a, ea);
      chk("exec_b", alu_b, eb);
      chk("exec_done", {7'd0, done}, 8'd0);
      chk("exec_rdy", {7'd0, instr_ready}, 8'd0);
      tick();
    end
    chk("wb_done", {7'd0, done}, 8'd1);
    chk("wb_br", {7'd0, branch_taken}, {7'd0, ebr});
    chk("wb_ill", {7'd0, illegal}, {7'd0, eill});
    chk("wb_op", {5'd0, alu_op}, 8'd7);
    tick();
    chk("idle_done", {7'd0, done}, 8'd0);
    chk("idle_rdy", {7'd0, instr_ready}, 8'd1);
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 8'h00;
    pre_we      = 1'b0;
    pre_sel     = 2'd0;
    pre_data    = 8'h00;
    dbg_sel     = 2'd0;
    #12;
    chk("rst_op", {5'd0, alu_op}, 8'd7);
    chk("rst_a", alu_a, 8'h00);
    chk("rst_b", alu_b, 8'h00);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_br", {7'd0, branch_taken}, 8'd0);
    chk("rst_ill", {7'd0, illegal}, 8'd0);
    for (int i = 0; i < 4; i++) chk_rf(i[1:0], 8'h00);
    rst_n = 1'b1;
    tick();
    chk("rst_rdy", {7'd0, instr_ready}, 8'd1);

    preload(2'd1, 8'h05);
    preload(2'd2, 8'h03);
    do_instr(8'b000_0_01_10, 8'h05, 8'h03, 1'b0, 1'b0);
    chk_rf(2'd1, 8'h08);
    chk_rf(2'd2, 8'h03);

    do_instr(8'b001_0_01_10, 8'h08, 8'h03, 1'b0, 1'b0);
    chk_rf(2'd1, 8'hFF);

    preload(2'd0, 8'h81);
    do_instr(8'b100_0_00_00, 8'h81, 8'h81, 1'b0, 1'b0);
    chk_rf(2'd0, 8'hC0);
    do_instr(8'b011_0_00_00, 8'hC0, 8'hC0, 1'b0, 1'b0);
    chk_rf(2'd0, 8'h80);

    preload(2'd2, 8'h2A);
    preload(2'd3, 8'h2A);
    do_instr(8'b101_0_10_11, 8'h2A, 8'h2A, 1'b1, 1'b0);
    chk_rf(2'd2, 8'h2A);
    chk_rf(2'd3, 8'h2A);
    preload(2'd3, 8'h2B);
    do_instr(8'b101_0_10_11, 8'h2A, 8'h2B, 1'b0, 1'b0);
    chk_rf(2'd2, 8'h2A);

    do_instr(8'b010_0_10_11, 8'h2A, 8'h2B, 1'b0, 1'b0);
    chk_rf(2'd2, 8'h00);
    do_instr(8'b010_0_11_11, 8'h2B, 8'h2B, 1'b0, 1'b0);
    chk_rf(2'd3, 8'h01);

    do_instr(8'b110_1_11_11, 8'h00, 8'h00, 1'b0, 1'b1);
    chk_rf(2'd0, 8'h80);
    chk_rf(2'd1, 8'hFF);
    chk_rf(2'd2, 8'h00);
    chk_rf(2'd3, 8'h01);
    do_instr(8'b111_0_00_01, 8'h00, 8'h00, 1'b0, 1'b1);
    chk_rf(2'd0, 8'h80);

    // preload racing a handshake: operand sees the old r1
    pre_we   = 1'b1;
    pre_sel  = 2'd1;
    pre_data = 8'h40;
    do_instr(8'b000_0_00_01, 8'h80, 8'hFF, 1'b0, 1'b0);
    chk_rf(2'd0, 8'h7F);
    chk_rf(2'd1, 8'h40);

    preload(2'd1, 8'h03);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("b2b_rdy%0d", i), {7'd0, instr_ready},
          {7'd0, (i % 3) == 0});
      chk($sformatf("b2b_done%0d", i), {7'd0, done},
          {7'd0, (i % 3) == 2});
      if ((i % 3) == 0) begin
        instr_valid = 1'b1;
        instr       = 8'b000_0_01_01;
        pre_we      = 1'b0;
      end else begin
        pre_we   = 1'b1;
        pre_sel  = 2'd3;
        pre_data = 8'h77;
      end
      tick();
    end
    instr_valid = 1'b0;
    pre_we      = 1'b0;
    chk_rf(2'd1, 8'h18);
    chk_rf(2'd3, 8'h01);

    preload(2'd0, 8'h10);
    preload(2'd1, 8'h20);
    instr_valid = 1'b1;
    instr       = 8'b000_0_00_01;
    tick();
    instr_valid = 1'b0;
    chk("arst_exec_op", {5'd0, alu_op}, 8'd0);
    chk("arst_exec_a", alu_a, 8'h10);
    rst_n = 1'b0;
    #1;
    chk("arst_op", {5'd0, alu_op}, 8'd7);
    chk("arst_a", alu_a, 8'h00);
    chk("arst_b", alu_b, 8'h00);
    chk("arst_done", {7'd0, done}, 8'd0);
    for (int i = 0; i < 4; i++) chk_rf(i[1:0], 8'h00);
    tick();
    chk("arst_done2", {7'd0, done}, 8'd0);
    rst_n = 1'b1;
    tick();
    chk("arst_done3", {7'd0, done}, 8'd0);
    chk("arst_rdy", {7'd0, instr_ready}, 8'd1);
    chk_rf(2'd0, 8'h00);
    chk_rf(2'd1, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: DATA_W, 8, operand/result width; only 8 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 instr_valid  input  1  instruction offered.
REQ-005 instr  input  8  [7:5] op, [3:2] rd/rs1, [1:0] rs2; bit 4 ignored.
REQ-006 instr_ready  output  1  high only in IDLE.
REQ-007 alu_op  output  3  opcode driven to the ALU.
REQ-008 alu_a  output  8  ALU data1.
REQ-009 alu_b  output  8  ALU data2.
REQ-010 alu_result  input  8  ALU result.
REQ-011 alu_zero  input  1  ALU equal flag.
REQ-012 pre_we  input  1  register preload strobe.
REQ-013 pre_sel  input  2  preload register index.
REQ-014 pre_data  input  8  preload value.
REQ-015 dbg_sel  input  2  debug read index.
REQ-016 dbg_data  output  8  combinational rf[dbg_sel].
REQ-017 done  output  1  one-cycle completion pulse.
REQ-018 branch_taken  output  1  one-cycle pulse, beq with equal operands.
REQ-019 illegal  output  1  one-cycle pulse, reserved opcode.

Function
REQ-020 Block shall own a 4 x 8-bit register file rf[0..3], all writable.
REQ-021 Op encoding: 000 add, 001 nand, 010 compare, 011 shl, 100 shr, 101 beq, 110/111 reserved.
REQ-022 FSM states IDLE, EXEC, WB; transitions IDLE->EXEC on handshake with legal op, IDLE->WB on handshake with reserved op, EXEC->WB, WB->IDLE, unconditionally.
REQ-023 Handshake = instr_valid && instr_ready at a rising edge; instr is sampled only then.
REQ-024 On handshake: alu_op<=op, alu_a<=rf[rs1], alu_b<=rf[rs2], rd<=instr[3:2], registered.
REQ-025 alu_op/alu_a/alu_b shall be stable for the whole EXEC cycle; outside EXEC alu_op=3'b111, alu_a/alu_b hold last values.
REQ-026 At EXEC->WB edge: ops 000-100 write alu_result into rf[rd]; op 101 writes nothing and latches alu_zero.
REQ-027 In WB: done=1; branch_taken=1 iff op 101 and latched zero=1; illegal=1 iff reserved op (done also 1, no rf write).
REQ-028 Latency: handshake edge N, EXEC cycle N..N+1, done high cycle N+1..N+2, instr_ready high again cycle N+2..; throughput 1 instruction / 3 cycles.
REQ-029 rd==rs1 or rs2 shall be legal; operands are captured before writeback.
REQ-030 pre_we shall write rf[pre_sel] only in IDLE; ignored in EXEC/WB.
REQ-031 pre_we with simultaneous handshake: instruction reads pre-write values; preload write takes effect.
REQ-032 Block shall not interpret or alter alu_result (compare-equal yields ALU's value verbatim).

Reset
REQ-033 rst_n low shall asynchronously force IDLE, rf all 0, alu_op=3'b111, alu_a=alu_b=0, done=branch_taken=illegal=0, instr_ready=1 after release.
REQ-034 Reset mid-EXEC or mid-WB shall abort with no rf write and no pulse.

Structure
REQ-035 Shared package alu_seq_pkg shall hold opcode constants, OP_IDLE=3'b111, and the state enum.
REQ-036 Register file shall be sub-module seq_regfile (2 async read ports, 1 debug read, 1 write port).

Verification
REQ-037 Preload r1=0x05, r2=0x03; instr 000_0_01_10 -> done 2 cycles later, rf[1]=0x08, alu_op=000 during EXEC only.
REQ-038 Preload r0=0x81; instr 100_0_00_00 with model ALU -> rf[0]=0xC0; then 011_0_00_00 -> rf[0]=0x80.
REQ-039 r2=r3=0x2A; instr 101_0_10_11 -> done and branch_taken same cycle, rf unchanged; r3=0x2B -> branch_taken=0.
REQ-040 instr 110_xxxxx -> illegal and done pulse 1 cycle after handshake, no EXEC, rf unchanged, alu_op stays 111.
REQ-041 Hold instr_valid high with back-to-back instrs -> instr_ready pattern 1,0,0 repeating; each instr accepted once; pre_we during EXEC ignored.
REQ-042 Assert rst_n low during EXEC of an add -> outputs at reset values immediately, rf all 0, no done pulse.
